quad_step_gen: RTL and testbench

Quadrature-encoder front end that turns two asynchronous encoder channels into single-cycle step requests for the saturating up/down counter. It synchronizes and glitch-filters `enc_a` and `enc_b`, then decodes Gray-code phase transitions. Each time the configured number of same-direction transitions accumulates, it emits one `count_en` pulse with `count_up1_dwn0` qualified. It sits between the board-level encoder pins and the counter's `count_en` / `count_up1_dwn0` inputs.

---
 rtl/quad_pkg.sv | 39 +++
 rtl/chan_filter.sv | 48 ++++
 rtl/quad_step_gen.sv | 95 +++++++++
 tb/tb_quad_step_gen.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/quad_pkg.sv
// Shared definitions for the quadrature step generator: phase encodings,
// transition codes, direction values and the Gray-code transition decoder.
package quad_pkg;

    localparam logic [1:0] PH_00 = 2'b00;
    localparam logic [1:0] PH_01 = 2'b01;
    localparam logic [1:0] PH_11 = 2'b11;
    localparam logic [1:0] PH_10 = 2'b10;

    typedef enum logic [1:0] {
        T_NONE,
        T_FWD,
        T_REV,
        T_ILLEGAL
    } trans_t;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // Forward order is 00 -> 01 -> 11 -> 10 -> 00; any single-bit change
    // that is not the forward successor is therefore the reverse one.
    function automatic trans_t decode_trans(input logic [1:0] prev, input logic [1:0] cur);
        trans_t t;
        if (prev == cur) begin
            t = T_NONE;
        end else if ((prev ^ cur) == 2'b11) begin
            t = T_ILLEGAL;
        end else begin
            case (prev)
                PH_00:   t = (cur == PH_01) ? T_FWD : T_REV;
                PH_01:   t = (cur == PH_11) ? T_FWD : T_REV;
                PH_11:   t = (cur == PH_10) ? T_FWD : T_REV;
                default: t = (cur == PH_00) ? T_FWD : T_REV;
            endcase
        end
        return t;
    endfunction

endpackage

// File: rtl/chan_filter.sv
// One encoder channel: multi-flop synchronizer followed by a debounce filter
// that accepts a new level only after it persists for FILT_CYCLES cycles.
module chan_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic filt
);

    localparam int CW = $clog2(FILT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt;
    logic                   synced;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

    // The counter tracks how long the synced level has disagreed with the
    // accepted level; the cycle it would hit FILT_CYCLES is the acceptance.
    always_ff @(posedge clk) begin
        if (reset) begin
            filt <= 1'b0;
            cnt  <= '0;
        end else if (synced != filt) begin
            if (cnt == CNT_LAST) begin
                filt <= synced;
                cnt  <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end else begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/quad_step_gen.sv
// Quadrature front end: filters both encoder channels, decodes Gray-code
// transitions and emits one counter step per DETENT_DIV same-direction moves.
module quad_step_gen
    import quad_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 4,
    parameter int DETENT_DIV  = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic enc_a,
    input  logic enc_b,
    output logic count_en,
    output logic count_up1_dwn0,
    output logic step_err
);

    localparam logic signed [3:0] ACC_MAX = 4'(DETENT_DIV - 1);
    localparam logic signed [3:0] ACC_MIN = -ACC_MAX;

    logic              a_f;
    logic              b_f;
    logic [1:0]        cur;
    logic [1:0]        prev;
    trans_t            trans_q;
    logic signed [3:0] acc;

    chan_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_CYCLES(FILT_CYCLES)) u_filt_a (
        .clk   (clk),
        .reset (reset),
        .raw   (enc_a),
        .filt  (a_f)
    );

    chan_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_CYCLES(FILT_CYCLES)) u_filt_b (
        .clk   (clk),
        .reset (reset),
        .raw   (enc_b),
        .filt  (b_f)
    );

    assign cur = {a_f, b_f};

    // The decoded transition is registered so the accumulator works from a
    // clean flop, which sets the overall input-to-step latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev    <= PH_00;
            trans_q <= T_NONE;
        end else begin
            prev    <= cur;
            trans_q <= decode_trans(prev, cur);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc            <= '0;
            count_en       <= 1'b0;
            count_up1_dwn0 <= DIR_DN;
            step_err       <= 1'b0;
        end else begin
            count_en <= 1'b0;
            step_err <= 1'b0;
            case (trans_q)
                T_FWD: begin
                    if (acc == ACC_MAX) begin
                        acc            <= '0;
                        count_en       <= 1'b1;
                        count_up1_dwn0 <= DIR_UP;
                    end else begin
                        acc <= acc + 4'sd1;
                    end
                end
                T_REV: begin
                    if (acc == ACC_MIN) begin
                        acc            <= '0;
                        count_en       <= 1'b1;
                        count_up1_dwn0 <= DIR_DN;
                    end else begin
                        acc <= acc - 4'sd1;
                    end
                end
                T_ILLEGAL: begin
                    acc      <= '0;
                    step_err <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_quad_step_gen.sv
// Self-checking bench for quad_step_gen: directed scenarios plus random
// encoder activity compared each cycle against a behavioural model.
module tb_quad_step_gen;

    localparam int SYNC_STAGES = 2;
    localparam int FILT_CYCLES = 4;
    localparam int DETENT_DIV  = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enc_a = 1'b0;
    logic enc_b = 1'b0;
    logic count_en;
    logic count_up1_dwn0;
    logic step_err;

    int total = 0;
    int bad   = 0;

    int cyc = 0;
    int seg_pulses = 0;
    int seg_errs = 0;
    int last_pulse_cyc = -1;

    // Model state: raw-sample history per channel, accepted levels, run
    // lengths, last phase, detent accumulator and a two-deep event delay.
    logic       m_hist[2][SYNC_STAGES];
    logic       m_filt[2];
    int         m_run[2];
    logic [1:0] m_prev = 2'b00;
    int         m_acc = 0;
    int         m_pipe[2];
    logic       exp_en = 1'b0;
    logic       exp_dir = 1'b0;
    logic       exp_err = 1'b0;

    quad_step_gen #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_CYCLES (FILT_CYCLES),
        .DETENT_DIV  (DETENT_DIV)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enc_a          (enc_a),
        .enc_b          (enc_b),
        .count_en       (count_en),
        .count_up1_dwn0 (count_up1_dwn0),
        .step_err       (step_err)
    );

    always #5 clk = ~clk;

    function automatic int ph_pos(input logic [1:0] p);
        case (p)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] ph_at(input int pos);
        case (pos % 4)
            0:       return 2'b00;
            1:       return 2'b01;
            2:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("[TB] FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, expv);
        end
    endtask

    task automatic modelStep(input logic rst, input logic ra, input logic rb);
        logic       seen;
        logic [1:0] cur;
        int         d;
        int         ev;
        if (rst) begin
            for (int ch = 0; ch < 2; ch++) begin
                for (int i = 0; i < SYNC_STAGES; i++) m_hist[ch][i] = 1'b0;
                m_filt[ch] = 1'b0;
                m_run[ch]  = 0;
            end
            m_prev  = 2'b00;
            m_acc   = 0;
            m_pipe[0] = 0;
            m_pipe[1] = 0;
            exp_en  = 1'b0;
            exp_dir = 1'b0;
            exp_err = 1'b0;
        end else begin
            ev = m_pipe[1];
            m_pipe[1] = m_pipe[0];
            exp_en  = (ev == 1) || (ev == 2);
            exp_err = (ev == 3);
            if (ev == 1) exp_dir = 1'b1;
            else if (ev == 2) exp_dir = 1'b0;

            for (int ch = 0; ch < 2; ch++) begin
                seen = m_hist[ch][SYNC_STAGES-1];
                for (int i = SYNC_STAGES - 1; i > 0; i--) m_hist[ch][i] = m_hist[ch][i-1];
                m_hist[ch][0] = (ch == 0) ? ra : rb;
                if (seen != m_filt[ch]) begin
                    m_run[ch]++;
                    if (m_run[ch] == FILT_CYCLES) begin
                        m_filt[ch] = seen;
                        m_run[ch]  = 0;
                    end
                end else begin
                    m_run[ch] = 0;
                end
            end

            cur = {m_filt[0], m_filt[1]};
            d   = (ph_pos(cur) - ph_pos(m_prev) + 4) % 4;
            ev  = 0;
            if (d == 1) begin
                if (m_acc == DETENT_DIV - 1) begin m_acc = 0; ev = 1; end
                else m_acc++;
            end else if (d == 3) begin
                if (m_acc == -(DETENT_DIV - 1)) begin m_acc = 0; ev = 2; end
                else m_acc--;
            end else if (d == 2) begin
                m_acc = 0;
                ev = 3;
            end
            m_prev    = cur;
            m_pipe[0] = ev;
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic [1:0] ab, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            reset = rst;
            enc_a = ab[1];
            enc_b = ab[0];
            @(posedge clk);
            cyc++;
            #1;
            modelStep(rst, ab[1], ab[0]);
            checkOutput("count_en", 32'(count_en), 32'(exp_en));
            checkOutput("count_up1_dwn0", 32'(count_up1_dwn0), 32'(exp_dir));
            checkOutput("step_err", 32'(step_err), 32'(exp_err));
            if (count_en) begin
                seg_pulses++;
                last_pulse_cyc = cyc;
            end
            if (step_err) seg_errs++;
        end
    endtask

    task automatic clearSeg();
        seg_pulses = 0;
        seg_errs   = 0;
    endtask

    initial begin
        int         edge_k;
        logic [1:0] cur_ab;
        logic [1:0] nxt;
        int         r;
        int         pos;

        m_pipe[0] = 0;
        m_pipe[1] = 0;

        // Reset, then idle at 00
        clearSeg();
        applyStimulus(1'b1, 2'b00, 3);
        applyStimulus(1'b0, 2'b00, 20);
        checkOutput("idle_pulses", 32'(seg_pulses), 32'd0);
        checkOutput("idle_errs", 32'(seg_errs), 32'd0);

        // One forward detent; pulse exactly 7 edges after the 4th edge is sampled
        clearSeg();
        last_pulse_cyc = -1;
        applyStimulus(1'b0, 2'b01, 10);
        applyStimulus(1'b0, 2'b11, 10);
        applyStimulus(1'b0, 2'b10, 10);
        checkOutput("fwd_early_pulses", 32'(seg_pulses), 32'd0);
        edge_k = cyc + 1;
        applyStimulus(1'b0, 2'b00, 12);
        checkOutput("fwd_pulses", 32'(seg_pulses), 32'd1);
        checkOutput("fwd_latency", 32'(last_pulse_cyc - edge_k), 32'd7);
        checkOutput("fwd_dir", 32'(count_up1_dwn0), 32'd1);

        // Glitch rejection: short pulse ignored, 6-cycle pulse decoded but nets zero
        clearSeg();
        applyStimulus(1'b0, 2'b10, 3);
        applyStimulus(1'b0, 2'b00, 15);
        applyStimulus(1'b0, 2'b10, 6);
        applyStimulus(1'b0, 2'b00, 15);
        checkOutput("glitch_pulses", 32'(seg_pulses), 32'd0);
        checkOutput("glitch_errs", 32'(seg_errs), 32'd0);

        // Reversal hysteresis
        clearSeg();
        applyStimulus(1'b0, 2'b01, 10);
        applyStimulus(1'b0, 2'b11, 10);
        applyStimulus(1'b0, 2'b10, 10);
        applyStimulus(1'b0, 2'b11, 10);
        applyStimulus(1'b0, 2'b01, 10);
        applyStimulus(1'b0, 2'b00, 10);
        checkOutput("rev_hyst_pulses", 32'(seg_pulses), 32'd0);
        applyStimulus(1'b0, 2'b10, 10);
        applyStimulus(1'b0, 2'b11, 10);
        applyStimulus(1'b0, 2'b01, 10);
        applyStimulus(1'b0, 2'b00, 12);
        checkOutput("rev_pulses", 32'(seg_pulses), 32'd1);
        checkOutput("rev_dir", 32'(count_up1_dwn0), 32'd0);

        // Illegal transition clears progress
        clearSeg();
        applyStimulus(1'b0, 2'b01, 10);
        applyStimulus(1'b0, 2'b11, 10);
        applyStimulus(1'b0, 2'b00, 12);
        checkOutput("illegal_errs", 32'(seg_errs), 32'd1);
        checkOutput("illegal_pulses", 32'(seg_pulses), 32'd0);
        applyStimulus(1'b0, 2'b01, 10);
        applyStimulus(1'b0, 2'b11, 10);
        applyStimulus(1'b0, 2'b10, 10);
        checkOutput("post_illegal_3fwd", 32'(seg_pulses), 32'd0);
        applyStimulus(1'b0, 2'b00, 12);
        checkOutput("post_illegal_4fwd", 32'(seg_pulses), 32'd1);

        // Reset mid-operation with accumulator at +3
        applyStimulus(1'b0, 2'b01, 10);
        applyStimulus(1'b0, 2'b11, 10);
        applyStimulus(1'b0, 2'b10, 10);
        clearSeg();
        applyStimulus(1'b1, 2'b10, 1);
        checkOutput("midreset_en", 32'(count_en), 32'd0);
        checkOutput("midreset_dir", 32'(count_up1_dwn0), 32'd0);
        applyStimulus(1'b0, 2'b10, 10);
        applyStimulus(1'b0, 2'b00, 12);
        checkOutput("midreset_pulses", 32'(seg_pulses), 32'd0);

        // Random encoder activity
        cur_ab = 2'b00;
        for (int s = 0; s < 300; s++) begin
            r   = $urandom_range(0, 99);
            pos = ph_pos(cur_ab);
            if (r < 40)      nxt = ph_at(pos + 1);
            else if (r < 80) nxt = ph_at(pos + 3);
            else if (r < 90) nxt = cur_ab ^ 2'b11;
            else             nxt = cur_ab;
            applyStimulus(($urandom_range(0, 49) == 0), nxt, $urandom_range(1, 12));
            cur_ab = nxt;
        end
        applyStimulus(1'b0, cur_ab, 12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
